mem_access_stage: RTL and testbench

- Memory-access stage directly downstream of the ALU (Logic_Unit).
- Consumes the ALU result as a load/store address or pass-through value, the second register-file read as store data, and the control bits from decode.
- Drives a single-outstanding request/acknowledge data-memory port with byte lanes, alignment checking and a timeout.
- Presents one writeback beat per accepted operation.

---
 rtl/mem_access_pkg.sv | 46 ++++
 rtl/mem_access_stage_align.sv | 38 +++
 rtl/mem_access_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: definitions shared by the memory-access stage.
//   - SIZE_* : access-size encodings carried on the 'size' control field
//   - state_t: request FSM states
//   - byte_enable / extend_load: lane helpers used by mem_lane_align
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 behaves the same

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  // Little-endian byte enables for an access of 'size' at byte offset addr_lo.
  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Pick the addressed lane out of a read word and widen it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  addr_lo,
                                              input logic        load_unsigned);
    logic [31:0] lane;
    logic [31:0] res;
    lane = rdata >> {addr_lo, 3'b000};
    case (size)
      SIZE_BYTE: res = {{24{~load_unsigned & lane[7]}}, lane[7:0]};
      SIZE_HALF: res = {{16{~load_unsigned & lane[15]}}, lane[15:0]};
      default:   res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// mem_lane_align: combinational lane logic for the memory-access stage.
//   in : size, addr_lo (byte offset), store_data, rdata, load_unsigned
//   out: be (byte enables), wdata (lane-replicated store data),
//        load_data (selected and extended read value), misalign
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  input  logic        load_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  always_comb begin
    be        = byte_enable(size, addr_lo);
    load_data = extend_load(rdata, size, addr_lo, load_unsigned);
    case (size)
      SIZE_BYTE: begin
        wdata    = {4{store_data[7:0]}};
        misalign = 1'b0;
      end
      SIZE_HALF: begin
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      default: begin
        wdata    = store_data;
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage behind the ALU.
//   in : operation (in_valid, alu_result, store_data, mem_read, mem_write,
//        size, load_unsigned, wb_reg_in, reg_write_in), dmem_ack/dmem_rdata
//   out: in_ready, single-outstanding dmem request (req/we/addr/be/wdata),
//        one writeback beat per operation (out_valid, wb_data, wb_reg, wb_en,
//        exc_misalign, exc_bus)
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [4:0]  wb_reg_in,
  input  logic        reg_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_en,
  output logic        exc_misalign,
  output logic        exc_bus
);

  // The counter holds (request cycles - 1), so the last allowed cycle is T-1.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        in_ready_q, in_ready_d;
  logic        dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [1:0]  addr_lo_q, addr_lo_d, size_q, size_d;
  logic        load_unsigned_q, load_unsigned_d, reg_write_q, reg_write_d;
  logic        is_load_q, is_load_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic        out_valid_q, out_valid_d, wb_en_q, wb_en_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_misalign_q, exc_misalign_d, exc_bus_q, exc_bus_d;

  logic        accept, is_mem;
  logic [1:0]  align_size, align_addr_lo;
  logic        align_unsigned, lane_misalign;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  assign accept = in_valid && in_ready_q;
  assign is_mem = mem_read || mem_write;

  // In IDLE the aligner examines the incoming operation (lanes and alignment);
  // once it is captured, the same logic serves the load-return path.
  assign align_size     = (state_q == ST_IDLE) ? size              : size_q;
  assign align_addr_lo  = (state_q == ST_IDLE) ? alu_result[1:0]   : addr_lo_q;
  assign align_unsigned = (state_q == ST_IDLE) ? load_unsigned     : load_unsigned_q;

  mem_lane_align u_align (
    .size          (align_size),
    .addr_lo       (align_addr_lo),
    .store_data    (store_data),
    .rdata         (dmem_rdata),
    .load_unsigned (align_unsigned),
    .be            (lane_be),
    .wdata         (lane_wdata),
    .load_data     (lane_load),
    .misalign      (lane_misalign)
  );

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    in_ready_d      = in_ready_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_be_d       = dmem_be_q;
    dmem_wdata_d    = dmem_wdata_q;
    addr_lo_d       = addr_lo_q;
    size_d          = size_q;
    load_unsigned_d = load_unsigned_q;
    reg_write_d     = reg_write_q;
    is_load_d       = is_load_q;
    wb_reg_d        = wb_reg_q;
    out_valid_d     = 1'b0;
    wb_data_d       = wb_data_q;
    wb_en_d         = wb_en_q;
    exc_misalign_d  = exc_misalign_q;
    exc_bus_d       = exc_bus_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          in_ready_d      = 1'b0;
          addr_lo_d       = alu_result[1:0];
          size_d          = size;
          load_unsigned_d = load_unsigned;
          reg_write_d     = reg_write_in;
          is_load_d       = mem_read;   // read+write together counts as a load
          wb_reg_d        = wb_reg_in;
          count_d         = 16'd0;
          exc_misalign_d  = 1'b0;
          exc_bus_d       = 1'b0;
          if (!is_mem) begin
            state_d     = ST_RESP;
            out_valid_d = 1'b1;
            wb_data_d   = alu_result;
            wb_en_d     = reg_write_in;
          end else if (lane_misalign) begin
            state_d        = ST_RESP;
            out_valid_d    = 1'b1;
            wb_data_d      = 32'd0;
            wb_en_d        = 1'b0;
            exc_misalign_d = 1'b1;
          end else begin
            state_d      = ST_WAIT_ACK;
            dmem_req_d   = 1'b1;
            dmem_we_d    = !mem_read;
            dmem_addr_d  = {alu_result[31:2], 2'b00};
            dmem_be_d    = lane_be;
            dmem_wdata_d = lane_wdata;
          end
        end
      end
      ST_WAIT_ACK: begin
        count_d = count_q + 16'd1;
        // Ack is checked first so it wins over a simultaneous timeout.
        if (dmem_ack) begin
          state_d     = ST_RESP;
          dmem_req_d  = 1'b0;
          out_valid_d = 1'b1;
          wb_data_d   = is_load_q ? lane_load : 32'd0;
          wb_en_d     = is_load_q && reg_write_q;
        end else if (count_q == TIMEOUT_LAST) begin
          state_d     = ST_RESP;
          dmem_req_d  = 1'b0;
          out_valid_d = 1'b1;
          wb_data_d   = 32'd0;
          wb_en_d     = 1'b0;
          exc_bus_d   = 1'b1;
        end
      end
      ST_RESP: begin
        state_d        = ST_IDLE;
        in_ready_d     = 1'b1;
        wb_en_d        = 1'b0;
        exc_misalign_d = 1'b0;
        exc_bus_d      = 1'b0;
      end
      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      count_q         <= 16'd0;
      in_ready_q      <= 1'b0;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= 32'd0;
      dmem_be_q       <= 4'd0;
      dmem_wdata_q    <= 32'd0;
      addr_lo_q       <= 2'd0;
      size_q          <= 2'd0;
      load_unsigned_q <= 1'b0;
      reg_write_q     <= 1'b0;
      is_load_q       <= 1'b0;
      wb_reg_q        <= 5'd0;
      out_valid_q     <= 1'b0;
      wb_data_q       <= 32'd0;
      wb_en_q         <= 1'b0;
      exc_misalign_q  <= 1'b0;
      exc_bus_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      in_ready_q      <= in_ready_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_be_q       <= dmem_be_d;
      dmem_wdata_q    <= dmem_wdata_d;
      addr_lo_q       <= addr_lo_d;
      size_q          <= size_d;
      load_unsigned_q <= load_unsigned_d;
      reg_write_q     <= reg_write_d;
      is_load_q       <= is_load_d;
      wb_reg_q        <= wb_reg_d;
      out_valid_q     <= out_valid_d;
      wb_data_q       <= wb_data_d;
      wb_en_q         <= wb_en_d;
      exc_misalign_q  <= exc_misalign_d;
      exc_bus_q       <= exc_bus_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_be      = dmem_be_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign out_valid    = out_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_reg       = wb_reg_q;
  assign wb_en        = wb_en_q;
  assign exc_misalign = exc_misalign_q;
  assign exc_bus      = exc_bus_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk, reset, in_valid, in_ready;
  logic [31:0] alu_result, store_data;
  logic        mem_read, mem_write, load_unsigned, reg_write_in;
  logic [1:0]  size;
  logic [4:0]  wb_reg_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        out_valid, wb_en, exc_misalign, exc_bus;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .load_unsigned(load_unsigned),
    .wb_reg_in(wb_reg_in), .reg_write_in(reg_write_in), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  typedef struct {
    bit          out_seen;
    int          lat;
    int          req_cycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    bit          req_stable;
    logic [31:0] wb_data;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic        exc_m;
    logic        exc_b;
    logic        ov_after;
  } obs_t;

  typedef struct {
    bit          misalign;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req_cycles;
    int          lat;
    bit          exc_b;
    logic [31:0] wb_data;
    bit          wb_en;
    bit          check_data;
  } exp_t;

  // Reference model: expected outcome of one operation, from the access rules.
  function automatic exp_t model(input logic [31:0] alu, input logic [31:0] sd,
                                 input bit rd, input bit wr, input logic [1:0] sz,
                                 input bit lu, input bit rw, input logic [31:0] rdata,
                                 input int ack_at);
    exp_t e;
    int nbytes, off;
    bit mem;
    longint unsigned mask, val;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(alu % 32'd4);
    mem = rd || wr;
    e.misalign = mem && (off % nbytes != 0);
    e.we = wr && !rd;
    e.addr = alu - (alu % 32'd4);
    e.be = 4'(((1 << nbytes) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % nbytes) +: 8];
    e.exc_b = 0; e.check_data = 1; e.wb_en = rw; e.wb_data = alu;
    e.req_cycles = 0; e.lat = 1;
    if (mem && !e.misalign) begin
      if (ack_at >= 1 && ack_at <= T) begin
        e.req_cycles = ack_at; e.lat = ack_at + 1;
      end else begin
        e.req_cycles = T; e.lat = T + 1; e.exc_b = 1;
      end
      if (e.exc_b || e.we) begin
        e.wb_en = 0; e.check_data = 0;
      end else begin
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        val = (64'(rdata) >> (8 * off)) & mask;
        if (!lu && nbytes < 4 && val[8*nbytes-1]) val = val | (~mask & 64'hFFFF_FFFF);
        e.wb_data = val[31:0];
      end
    end else if (mem) begin
      e.wb_en = 0; e.check_data = 0;
    end
    return e;
  endfunction

  // Drive one operation and observe the resulting bus activity and writeback.
  // ack_at = request cycle (1-based) in which the memory acknowledges; 0 = never.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] sd,
                        input bit rd, input bit wr, input logic [1:0] sz,
                        input bit lu, input bit rw, input logic [4:0] reg_id,
                        input logic [31:0] rdata, input int ack_at, output obs_t o);
    int guard;
    o = '{default: 0};
    o.req_stable = 1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1; alu_result = alu; store_data = sd; mem_read = rd; mem_write = wr;
    size = sz; load_unsigned = lu; reg_write_in = rw; wb_reg_in = reg_id;
    @(negedge clk);
    in_valid = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      dmem_ack = 0;
      dmem_rdata = $urandom;
      if (dmem_req) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.wdata = dmem_wdata;
        end else if (o.addr !== dmem_addr || o.be !== dmem_be || o.we !== dmem_we ||
                     o.wdata !== dmem_wdata) begin
          o.req_stable = 0;
        end
        if (o.req_cycles == ack_at) begin
          dmem_ack = 1; dmem_rdata = rdata;
        end
      end
      if (out_valid) begin
        o.out_seen = 1; o.lat = cyc; o.wb_data = wb_data; o.wb_en = wb_en;
        o.wb_reg = wb_reg; o.exc_m = exc_misalign; o.exc_b = exc_bus;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    dmem_ack = 0;
    o.ov_after = out_valid;
    $display("op alu=%h sd=%h rd=%0d wr=%0d sz=%0d lu=%0d ack_at=%0d -> lat=%0d req=%0d be=%b wb=%h en=%0d exc=%0d%0d",
             alu, sd, rd, wr, sz, lu, ack_at, o.lat, o.req_cycles, o.be, o.wb_data,
             o.wb_en, o.exc_m, o.exc_b);
  endtask

  task automatic test_reset();
    logic [111:0] outs;
    reset = 1;
    repeat (2) @(negedge clk);
    outs = {in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid,
            wb_data[31:0], wb_reg, wb_en, exc_misalign, exc_bus};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs actual=%h required=0", outs);
    else n_pass++;
    reset = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready actual=%b required=1", in_ready);
    else n_pass++;
    $display("reset released, in_ready=%b", in_ready);
  endtask

  task automatic test_nonmem();
    obs_t o;
    run_op(32'h0000_0005, 32'h0, 0, 0, 2'd2, 0, 1, 5'd7, 32'h0, 0, o);
    n_checks++;
    if (o.lat != 1) $display("FAIL nonmem_latency actual=%0d required=1", o.lat); else n_pass++;
    n_checks++;
    if (o.wb_data !== 32'h5 || o.wb_en !== 1'b1 || o.wb_reg !== 5'd7)
      $display("FAIL nonmem_wb actual=%h/%b/%0d required=00000005/1/7", o.wb_data, o.wb_en, o.wb_reg);
    else n_pass++;
    n_checks++;
    if (o.req_cycles != 0 || o.ov_after !== 1'b0)
      $display("FAIL nonmem_noreq actual req=%0d ov_after=%b required 0/0", o.req_cycles, o.ov_after);
    else n_pass++;
  endtask

  task automatic test_store();
    obs_t o;
    run_op(32'h0000_1003, 32'hAABB_CCDD, 0, 1, 2'd0, 0, 1, 5'd3, 32'h0, 3, o);
    n_checks++;
    if (o.addr !== 32'h1000 || o.be !== 4'b1000 || o.we !== 1'b1)
      $display("FAIL store_bus actual addr=%h be=%b we=%b required 00001000/1000/1", o.addr, o.be, o.we);
    else n_pass++;
    n_checks++;
    if (o.wdata !== 32'hDDDD_DDDD) $display("FAIL store_wdata actual=%h required=dddddddd", o.wdata);
    else n_pass++;
    n_checks++;
    if (o.req_cycles != 3 || o.lat != 4 || !o.req_stable)
      $display("FAIL store_timing actual req=%0d lat=%0d stable=%0d required 3/4/1", o.req_cycles, o.lat, o.req_stable);
    else n_pass++;
    n_checks++;
    if (o.wb_en !== 1'b0 || o.exc_b !== 1'b0) $display("FAIL store_wben actual=%b/%b required=0/0", o.wb_en, o.exc_b);
    else n_pass++;
  endtask

  task automatic test_load_half();
    obs_t o;
    run_op(32'h0000_2002, 32'h0, 1, 0, 2'd1, 0, 1, 5'd9, 32'h8001_1234, 1, o);
    n_checks++;
    if (o.wb_data !== 32'hFFFF_8001 || o.wb_en !== 1'b1 || o.lat != 2)
      $display("FAIL load_half_signed actual=%h en=%b lat=%0d required ffff8001/1/2", o.wb_data, o.wb_en, o.lat);
    else n_pass++;
    n_checks++;
    if (o.be !== 4'b1100 || o.we !== 1'b0 || o.addr !== 32'h2000)
      $display("FAIL load_half_bus actual be=%b we=%b addr=%h required 1100/0/00002000", o.be, o.we, o.addr);
    else n_pass++;
    run_op(32'h0000_2002, 32'h0, 1, 0, 2'd1, 1, 1, 5'd9, 32'h8001_1234, 1, o);
    n_checks++;
    if (o.wb_data !== 32'h0000_8001) $display("FAIL load_half_unsigned actual=%h required=00008001", o.wb_data);
    else n_pass++;
  endtask

  task automatic test_misalign();
    obs_t o;
    run_op(32'h0000_3001, 32'h0, 1, 0, 2'd2, 0, 1, 5'd4, 32'h0, 1, o);
    n_checks++;
    if (o.req_cycles != 0 || o.lat != 1)
      $display("FAIL misalign_timing actual req=%0d lat=%0d required 0/1", o.req_cycles, o.lat);
    else n_pass++;
    n_checks++;
    if (o.exc_m !== 1'b1 || o.wb_en !== 1'b0 || o.exc_b !== 1'b0)
      $display("FAIL misalign_flags actual m=%b en=%b b=%b required 1/0/0", o.exc_m, o.wb_en, o.exc_b);
    else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(32'h0000_4000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd11, 32'h1234_5678, 0, o);
    n_checks++;
    if (o.req_cycles != T || o.lat != T + 1)
      $display("FAIL timeout_timing actual req=%0d lat=%0d required %0d/%0d", o.req_cycles, o.lat, T, T + 1);
    else n_pass++;
    n_checks++;
    if (o.exc_b !== 1'b1 || o.wb_en !== 1'b0)
      $display("FAIL timeout_flags actual b=%b en=%b required 1/0", o.exc_b, o.wb_en);
    else n_pass++;
    run_op(32'h0000_4000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd11, 32'h1234_5678, T, o);
    n_checks++;
    if (o.exc_b !== 1'b0 || o.wb_data !== 32'h1234_5678 || o.wb_en !== 1'b1 || o.lat != T + 1)
      $display("FAIL ack_last_cycle actual b=%b wb=%h en=%b lat=%0d required 0/12345678/1/%0d",
               o.exc_b, o.wb_data, o.wb_en, o.lat, T + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic req_seen;
    int ov_count;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1; alu_result = 32'h40; mem_read = 1; mem_write = 0; size = 2'd2;
    reg_write_in = 1; wb_reg_in = 5'd2;
    @(negedge clk);
    in_valid = 0;
    req_seen = dmem_req;
    @(negedge clk);
    reset = 1;
    #1;
    n_checks++;
    if (req_seen !== 1'b1 || dmem_req !== 1'b0)
      $display("FAIL reset_mid_req actual before=%b after=%b required 1/0", req_seen, dmem_req);
    else n_pass++;
    @(negedge clk);
    reset = 0;
    ov_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_ack = 1;
      dmem_rdata = 32'hDEAD_BEEF;
      if (out_valid) ov_count++;
    end
    @(negedge clk);
    if (out_valid) ov_count++;
    dmem_ack = 0;
    n_checks++;
    if (ov_count != 0 || in_ready !== 1'b1)
      $display("FAIL stale_ack actual out_valid_count=%0d ready=%b required 0/1", ov_count, in_ready);
    else n_pass++;
    $display("reset mid-transaction: stale ack pulses=%0d out_valid seen=%0d", 4, ov_count);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] exp_v;
    int outs, bad;
    outs = 0; bad = 0;
    @(negedge clk);
    mem_read = 0; mem_write = 0; reg_write_in = 1; wb_reg_in = 5'd1;
    in_valid = 1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        outs++;
        exp_v = (q.size() > 0) ? q.pop_front() : 32'hX;
        if (wb_data !== exp_v) bad++;
      end
      if (in_ready) begin
        alu_result = $urandom;
        q.push_back(alu_result);
      end
    end
    in_valid = 0;
    $display("back-to-back: %0d results, %0d data errors", outs, bad);
    n_checks++;
    if (outs != 10) $display("FAIL b2b_throughput actual=%0d required=10", outs); else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL b2b_data actual_errors=%0d required=0", bad); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [31:0] alu, sd, rdata;
    logic [1:0] sz;
    logic [4:0] rid;
    bit rd, wr, lu, rw;
    int kind, ack_at;
    for (int n = 0; n < 40; n++) begin
      alu = $urandom; sd = $urandom; rdata = $urandom;
      sz = 2'($urandom_range(0, 3)); rid = 5'($urandom_range(0, 31));
      kind = $urandom_range(0, 3);
      rd = (kind == 1 || kind == 3); wr = (kind == 2 || kind == 3);
      lu = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      ack_at = $urandom_range(0, 6);
      e = model(alu, sd, rd, wr, sz, lu, rw, rdata, ack_at);
      run_op(alu, sd, rd, wr, sz, lu, rw, rid, rdata, ack_at, o);
      n_checks++;
      if (!o.out_seen || o.lat != e.lat || o.req_cycles != e.req_cycles || o.ov_after !== 1'b0)
        $display("FAIL rnd%0d_timing actual lat=%0d req=%0d after=%b required %0d/%0d/0",
                 n, o.lat, o.req_cycles, o.ov_after, e.lat, e.req_cycles);
      else n_pass++;
      if (e.req_cycles > 0) begin
        n_checks++;
        if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we || !o.req_stable ||
            (e.we && o.wdata !== e.wdata))
          $display("FAIL rnd%0d_bus actual addr=%h be=%b we=%b wd=%h st=%0d required %h/%b/%b/%h/1",
                   n, o.addr, o.be, o.we, o.wdata, o.req_stable, e.addr, e.be, e.we, e.wdata);
        else n_pass++;
      end
      n_checks++;
      if (o.exc_m !== e.misalign || o.exc_b !== e.exc_b || o.wb_en !== e.wb_en || o.wb_reg !== rid)
        $display("FAIL rnd%0d_flags actual m=%b b=%b en=%b reg=%0d required %b/%b/%b/%0d",
                 n, o.exc_m, o.exc_b, o.wb_en, o.wb_reg, e.misalign, e.exc_b, e.wb_en, rid);
      else n_pass++;
      if (e.check_data) begin
        n_checks++;
        if (o.wb_data !== e.wb_data)
          $display("FAIL rnd%0d_data actual=%h required=%h", n, o.wb_data, e.wb_data);
        else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; alu_result = 0; store_data = 0; mem_read = 0;
    mem_write = 0; size = 0; load_unsigned = 0; wb_reg_in = 0; reg_write_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
    test_reset();
    test_nonmem();
    test_store();
    test_load_half();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
